pc_sequencer: RTL and testbench

Next-PC and pipeline-steering controller for the 5-stage core. It sits beside the PC register, chooses the next fetch address each cycle and drives the register's hold input. It also issues keep/flush controls to the IF/ID and ID/EX pipeline registers and arbitrates between stall, redirect and interrupt sources. It owns the interrupt-pending latch, handler-mode state, EPC and a stall-cycle counter.

---
 rtl/pipeline_ctrl_pkg.sv | 14 +
 rtl/stall_counter.sv | 27 ++
 rtl/pc_sequencer.sv | 150 +++++++++++++++
 tb/tb_pc_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline control slice: sequencer states and
// default PC constants used by the next-PC logic.
package pipeline_ctrl_pkg;

    typedef enum logic [0:0] {
        NORMAL  = 1'b0,
        HANDLER = 1'b1
    } state_t;

    localparam logic [31:0] PC_STEP            = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_HANDLER_PC = 32'h8000_0004;

endpackage

// File: rtl/stall_counter.sv
// Wrapping enable counter with asynchronous active-high reset; generic enough
// to count stall, flush or interrupt events.
module stall_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_r;

    // Event counter, wraps naturally at 2^WIDTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {WIDTH{1'b0}};
        end else if (en) begin
            count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC and pipeline-steering controller: picks the fetch address, drives
// PC hold and IF/ID, ID/EX keep/flush, and tracks interrupt/handler state.
module pc_sequencer
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [31:0] HANDLER_PC = DEFAULT_HANDLER_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_pc,
    input  logic        i_id_valid,
    input  logic [31:0] i_id_pc,
    input  logic        i_id_jump,
    input  logic [31:0] i_id_jump_target,
    input  logic        i_id_eret,
    input  logic        i_ex_branch_taken,
    input  logic [31:0] i_ex_branch_target,
    input  logic        i_load_use,
    input  logic        i_mc_busy,
    input  logic        i_irq,
    input  logic        i_irq_en,
    output logic [31:0] o_next_pc,
    output logic        o_pc_keep,
    output logic        o_ifid_keep,
    output logic        o_ifid_flush,
    output logic        o_idex_keep,
    output logic        o_idex_flush,
    output logic [31:0] o_epc,
    output logic        o_in_handler,
    output logic [31:0] o_stall_cnt
);

    state_t      state_r;
    state_t      next_state_s;
    logic [31:0] epc_r;
    logic        irq_pending_r;

    logic        eret_go_s;
    logic        take_irq_s;
    logic [31:0] next_pc_s;
    logic        pc_keep_s;
    logic        ifid_keep_s;
    logic        ifid_flush_s;
    logic        idex_keep_s;
    logic        idex_flush_s;

    assign eret_go_s  = i_id_eret & i_id_valid & (state_r == HANDLER)
                        & ~i_mc_busy & ~i_ex_branch_taken;
    assign take_irq_s = irq_pending_r & i_irq_en & (state_r == NORMAL)
                        & ~i_mc_busy & ~i_ex_branch_taken & ~eret_go_s & ~i_load_use;

    // Strict-priority steering decision; reset forces the fetch to RESET_PC with both stages flushed.
    always_comb begin
        next_pc_s    = i_pc + PC_STEP;
        pc_keep_s    = 1'b0;
        ifid_keep_s  = 1'b0;
        ifid_flush_s = 1'b0;
        idex_keep_s  = 1'b0;
        idex_flush_s = 1'b0;
        if (reset) begin
            next_pc_s    = RESET_PC;
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
        end else if (i_mc_busy) begin
            next_pc_s   = i_pc;
            pc_keep_s   = 1'b1;
            ifid_keep_s = 1'b1;
            idex_keep_s = 1'b1;
        end else if (i_ex_branch_taken) begin
            next_pc_s    = i_ex_branch_target;
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
        end else if (eret_go_s) begin
            next_pc_s    = epc_r;
            ifid_flush_s = 1'b1;
        end else if (take_irq_s) begin
            next_pc_s    = HANDLER_PC;
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
        end else if (i_load_use) begin
            // A jump sharing this cycle stays in ID and is retried next cycle.
            next_pc_s    = i_pc;
            pc_keep_s    = 1'b1;
            ifid_keep_s  = 1'b1;
            idex_flush_s = 1'b1;
        end else if (i_id_jump & i_id_valid) begin
            next_pc_s    = i_id_jump_target;
            ifid_flush_s = 1'b1;
        end else begin
            next_pc_s = i_pc + PC_STEP;
        end
    end

    // Handler-mode transitions; ERET seen in NORMAL is a NOP.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            NORMAL: begin
                if (take_irq_s) begin
                    next_state_s = HANDLER;
                end else begin
                    next_state_s = NORMAL;
                end
            end
            HANDLER: begin
                if (eret_go_s) begin
                    next_state_s = NORMAL;
                end else begin
                    next_state_s = HANDLER;
                end
            end
            default: next_state_s = NORMAL;
        endcase
    end

    // State, EPC capture and level-sensitive interrupt-pending latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= NORMAL;
            epc_r         <= 32'h0000_0000;
            irq_pending_r <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            irq_pending_r <= (irq_pending_r & ~take_irq_s) | i_irq;
            if (take_irq_s) begin
                epc_r <= i_id_valid ? i_id_pc : i_pc;
            end else begin
                epc_r <= epc_r;
            end
        end
    end

    stall_counter #(.WIDTH(32)) u_stall_counter (
        .clk   (clk),
        .reset (reset),
        .en    (pc_keep_s & ~reset),
        .count (o_stall_cnt)
    );

    assign o_next_pc    = next_pc_s;
    assign o_pc_keep    = pc_keep_s;
    assign o_ifid_keep  = ifid_keep_s;
    assign o_ifid_flush = ifid_flush_s;
    assign o_idex_keep  = idex_keep_s;
    assign o_idex_flush = idex_flush_s;
    assign o_epc        = epc_r;
    assign o_in_handler = (state_r == HANDLER);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; control outputs are compared
// as the vector {pc_keep, ifid_keep, ifid_flush, idex_keep, idex_flush}.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic [31:0] i_pc;
    logic        i_id_valid;
    logic [31:0] i_id_pc;
    logic        i_id_jump;
    logic [31:0] i_id_jump_target;
    logic        i_id_eret;
    logic        i_ex_branch_taken;
    logic [31:0] i_ex_branch_target;
    logic        i_load_use;
    logic        i_mc_busy;
    logic        i_irq;
    logic        i_irq_en;
    logic [31:0] o_next_pc;
    logic        o_pc_keep;
    logic        o_ifid_keep;
    logic        o_ifid_flush;
    logic        o_idex_keep;
    logic        o_idex_flush;
    logic [31:0] o_epc;
    logic        o_in_handler;
    logic [31:0] o_stall_cnt;

    int          total_cnt;
    int          pass_cnt;
    logic [31:0] exp_stall;
    logic [4:0]  ctrl;

    assign ctrl = {o_pc_keep, o_ifid_keep, o_ifid_flush, o_idex_keep, o_idex_flush};

    pc_sequencer dut (
        .clk(clk), .reset(reset), .i_pc(i_pc), .i_id_valid(i_id_valid), .i_id_pc(i_id_pc),
        .i_id_jump(i_id_jump), .i_id_jump_target(i_id_jump_target), .i_id_eret(i_id_eret),
        .i_ex_branch_taken(i_ex_branch_taken), .i_ex_branch_target(i_ex_branch_target),
        .i_load_use(i_load_use), .i_mc_busy(i_mc_busy), .i_irq(i_irq), .i_irq_en(i_irq_en),
        .o_next_pc(o_next_pc), .o_pc_keep(o_pc_keep), .o_ifid_keep(o_ifid_keep),
        .o_ifid_flush(o_ifid_flush), .o_idex_keep(o_idex_keep), .o_idex_flush(o_idex_flush),
        .o_epc(o_epc), .o_in_handler(o_in_handler), .o_stall_cnt(o_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_pc = 32'h100; i_id_valid = 1'b0; i_id_pc = 32'h0; i_id_jump = 1'b0;
        i_id_jump_target = 32'h0; i_id_eret = 1'b0; i_ex_branch_taken = 1'b0;
        i_ex_branch_target = 32'h0; i_load_use = 1'b0; i_mc_busy = 1'b0;
        i_irq = 1'b0; i_irq_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        #3;
        total_cnt++;
        if (o_next_pc !== 32'h0 || ctrl !== 5'b00101) $display("FAIL reset_steer next_pc=%h ctrl=%b exp 00000000/00101", o_next_pc, ctrl);
        else pass_cnt++;
        total_cnt++;
        if (o_epc !== 32'h0 || o_in_handler !== 1'b0 || o_stall_cnt !== 32'h0)
            $display("FAIL reset_state epc=%h hand=%b cnt=%h exp 0/0/0", o_epc, o_in_handler, o_stall_cnt);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        exp_stall = 32'h0;
        #1;
    endtask

    task automatic test_free_run();
        i_pc = 32'h100;
        #1;
        total_cnt++;
        if (o_next_pc !== 32'h104 || ctrl !== 5'b00000) $display("FAIL free_run next_pc=%h ctrl=%b exp 00000104/00000", o_next_pc, ctrl);
        else pass_cnt++;
        i_pc = 32'hFFFF_FFFC;
        #1;
        total_cnt++;
        if (o_next_pc !== 32'h0) $display("FAIL pc_wrap next_pc=%h exp 00000000", o_next_pc);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_load_use_jump();
        i_pc = 32'h108; i_id_valid = 1'b1; i_id_pc = 32'h104;
        i_id_jump = 1'b1; i_id_jump_target = 32'h400; i_load_use = 1'b1;
        #1;
        total_cnt++;
        if (o_next_pc !== 32'h108 || ctrl !== 5'b11001) $display("FAIL load_use next_pc=%h ctrl=%b exp 00000108/11001", o_next_pc, ctrl);
        else pass_cnt++;
        tick();
        exp_stall = exp_stall + 32'd1;
        i_load_use = 1'b0;
        #1;
        total_cnt++;
        if (o_next_pc !== 32'h400 || ctrl !== 5'b00100) $display("FAIL jump_retry next_pc=%h ctrl=%b exp 00000400/00100", o_next_pc, ctrl);
        else pass_cnt++;
        total_cnt++;
        if (o_stall_cnt !== exp_stall) $display("FAIL stall_cnt_lu got %h exp %h", o_stall_cnt, exp_stall);
        else pass_cnt++;
        tick();
        idle_inputs();
    endtask

    task automatic test_branch_priority();
        i_irq = 1'b1; i_irq_en = 1'b1; i_pc = 32'h120;
        tick();
        i_irq = 1'b0; i_ex_branch_taken = 1'b1; i_ex_branch_target = 32'h200; i_load_use = 1'b1;
        #1;
        total_cnt++;
        if (o_next_pc !== 32'h200 || ctrl !== 5'b00101) $display("FAIL branch_prio next_pc=%h ctrl=%b exp 00000200/00101", o_next_pc, ctrl);
        else pass_cnt++;
        tick();
        i_ex_branch_taken = 1'b0; i_load_use = 1'b0; i_pc = 32'h200;
        #1;
        total_cnt++;
        if (o_next_pc !== 32'h8000_0004 || ctrl !== 5'b00101) $display("FAIL irq_after_branch next_pc=%h ctrl=%b exp 80000004/00101", o_next_pc, ctrl);
        else pass_cnt++;
        tick();
        i_pc = 32'h8000_0004;
        #1;
        total_cnt++;
        if (o_in_handler !== 1'b1 || o_epc !== 32'h200) $display("FAIL epc_from_pc hand=%b epc=%h exp 1/00000200", o_in_handler, o_epc);
        else pass_cnt++;
        i_id_valid = 1'b1; i_id_eret = 1'b1; i_id_pc = 32'h8000_0004;
        tick();
        idle_inputs();
    endtask

    task automatic test_irq_eret();
        i_irq = 1'b1; i_irq_en = 1'b1; i_id_valid = 1'b1; i_id_pc = 32'h40; i_pc = 32'h44;
        #1;
        total_cnt++;
        if (o_next_pc !== 32'h48 || o_in_handler !== 1'b0) $display("FAIL irq_latency next_pc=%h hand=%b exp 00000048/0", o_next_pc, o_in_handler);
        else pass_cnt++;
        tick();
        i_irq = 1'b0;
        #1;
        total_cnt++;
        if (o_next_pc !== 32'h8000_0004 || ctrl !== 5'b00101) $display("FAIL irq_take next_pc=%h ctrl=%b exp 80000004/00101", o_next_pc, ctrl);
        else pass_cnt++;
        tick();
        i_pc = 32'h8000_0004; i_id_valid = 1'b0;
        #1;
        total_cnt++;
        if (o_in_handler !== 1'b1 || o_epc !== 32'h40) $display("FAIL irq_epc hand=%b epc=%h exp 1/00000040", o_in_handler, o_epc);
        else pass_cnt++;
        i_id_valid = 1'b1; i_id_eret = 1'b1; i_id_pc = 32'h8000_0008; i_pc = 32'h8000_000C;
        #1;
        total_cnt++;
        if (o_next_pc !== 32'h40 || ctrl !== 5'b00100) $display("FAIL eret next_pc=%h ctrl=%b exp 00000040/00100", o_next_pc, ctrl);
        else pass_cnt++;
        tick();
        i_pc = 32'h40;
        #1;
        total_cnt++;
        if (o_in_handler !== 1'b0 || o_next_pc !== 32'h44 || ctrl !== 5'b00000)
            $display("FAIL eret_in_normal hand=%b next_pc=%h ctrl=%b exp 0/00000044/00000", o_in_handler, o_next_pc, ctrl);
        else pass_cnt++;
        tick();
        idle_inputs();
    endtask

    task automatic test_mc_busy();
        i_pc = 32'h500; i_mc_busy = 1'b1; i_ex_branch_taken = 1'b1; i_ex_branch_target = 32'h300;
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++;
            if (o_next_pc !== 32'h500 || ctrl !== 5'b11010) $display("FAIL mc_busy_%0d next_pc=%h ctrl=%b exp 00000500/11010", i, o_next_pc, ctrl);
            else pass_cnt++;
            tick();
            exp_stall = exp_stall + 32'd1;
        end
        i_mc_busy = 1'b0;
        #1;
        total_cnt++;
        if (o_next_pc !== 32'h300 || ctrl !== 5'b00101) $display("FAIL busy_release next_pc=%h ctrl=%b exp 00000300/00101", o_next_pc, ctrl);
        else pass_cnt++;
        total_cnt++;
        if (o_stall_cnt !== exp_stall) $display("FAIL stall_cnt_busy got %h exp %h", o_stall_cnt, exp_stall);
        else pass_cnt++;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_in_handler();
        i_load_use = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_stall = exp_stall + 32'd1;
        end
        i_load_use = 1'b0; i_irq = 1'b1; i_irq_en = 1'b1;
        tick();
        i_irq = 1'b0;
        tick();
        total_cnt++;
        if (o_in_handler !== 1'b1 || o_stall_cnt !== 32'd7 || exp_stall !== 32'd7)
            $display("FAIL pre_reset hand=%b cnt=%h exp 1/00000007", o_in_handler, o_stall_cnt);
        else pass_cnt++;
        #2;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (o_in_handler !== 1'b0 || o_epc !== 32'h0 || o_stall_cnt !== 32'h0)
            $display("FAIL async_reset hand=%b epc=%h cnt=%h exp 0/0/0", o_in_handler, o_epc, o_stall_cnt);
        else pass_cnt++;
        total_cnt++;
        if (o_next_pc !== 32'h0 || ctrl !== 5'b00101) $display("FAIL async_reset_steer next_pc=%h ctrl=%b exp 00000000/00101", o_next_pc, ctrl);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        exp_stall = 32'h0;
        test_reset();
        test_free_run();
        test_load_use_jump();
        test_branch_priority();
        test_irq_eret();
        test_mc_busy();
        test_reset_in_handler();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
